// File: rtl/branch_pkg.sv
// branch_pkg: shared definitions for the branch unit and the instruction decoder.
// Holds the branch-op encoding, the op field width and default widths for the
// program counter, target-table index and return-stack depth.
package branch_pkg;

  localparam int BR_OP_W         = 3;
  localparam int PC_W_DEF        = 10;
  localparam int LUT_AW_DEF      = 4;
  localparam int STACK_DEPTH_DEF = 4;

  // Codes 5..7 are not listed and decode as BR_NONE.
  typedef enum logic [BR_OP_W-1:0] {
    BR_NONE = 3'd0,
    BR_JMP  = 3'd1,
    BR_BEQ  = 3'd2,
    BR_CALL = 3'd3,
    BR_RET  = 3'd4
  } br_op_e;

endpackage

// File: rtl/branch_unit_if.sv
// branch_unit_if: signal bundle between the fetch/decode side and branch_unit.
//   master : fetch/decode side (drives the instruction fields, flag and table writes)
//   slave  : branch_unit (returns BranchEn, BranchOnFlag, branch_flag, Target, StackErr)
interface branch_unit_if
  import branch_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) ();

  logic                Start;
  logic [PC_W-1:0]     ProgCtr;
  logic [BR_OP_W-1:0]  BrOp;
  logic [LUT_AW-1:0]   BrIdx;
  logic                FlagWr;
  logic                CmpFlag;
  logic                LutWe;
  logic [LUT_AW-1:0]   LutAddr;
  logic [PC_W-1:0]     LutData;
  logic                BranchEn;
  logic                BranchOnFlag;
  logic                branch_flag;
  logic [PC_W-1:0]     Target;
  logic                StackErr;

  modport master (
    output Start, ProgCtr, BrOp, BrIdx, FlagWr, CmpFlag, LutWe, LutAddr, LutData,
    input  BranchEn, BranchOnFlag, branch_flag, Target, StackErr
  );

  modport slave (
    input  Start, ProgCtr, BrOp, BrIdx, FlagWr, CmpFlag, LutWe, LutAddr, LutData,
    output BranchEn, BranchOnFlag, branch_flag, Target, StackErr
  );

endinterface

// File: rtl/ret_stack.sv
// ret_stack: small LIFO holding return addresses.
// Ports: Clk, Reset (sync, active-low), clr (sync clear), push/push_data,
//        pop, full, empty, top (0 when empty).
// A push while full and a pop while empty are ignored; the caller flags them.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_m1;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign cnt_m1  = cnt - 1'b1;
  assign wr_idx  = AW'(cnt);
  assign top_idx = AW'(cnt_m1);
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign top     = empty ? '0 : mem[top_idx];

  // Clearing the count is enough to discard contents; storage needs no reset.
  always_ff @(posedge Clk) begin
    if (!Reset || clr) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt_m1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset && !clr && push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/branch_unit.sv
// branch_unit: branch control for InstFetch. Decodes BrOp, holds the compare
// flag, resolves targets through a loadable target table and, when
// BRANCH_RET_STACK_EN is defined, maintains a call/return stack.
// Ports: Clk, Reset (sync, active-low), bus (branch_unit_if.slave).
// Branch outputs are combinational; flag, table, stack and StackErr are registered.
// Build option BRANCH_RET_STACK_EN: without it CALL acts as JMP, RET as NONE,
// and StackErr is tied low.
module branch_unit
  import branch_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int LUT_AW      = LUT_AW_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  branch_unit_if.slave bus
);

  logic [PC_W-1:0] lut_q [2**LUT_AW];
  logic            flag_q;
  logic            br_en;
  logic            on_flag;
  logic [PC_W-1:0] tgt;

`ifdef BRANCH_RET_STACK_EN
  logic            do_push;
  logic            do_pop;
  logic            stk_fault;
  logic            stk_full;
  logic            stk_empty;
  logic [PC_W-1:0] stk_top;
  logic            err_q;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .Clk       (Clk),
    .Reset     (Reset),
    .clr       (bus.Start),
    .push      (do_push),
    .push_data (bus.ProgCtr + PC_W'(1)),
    .pop       (do_pop),
    .full      (stk_full),
    .empty     (stk_empty),
    .top       (stk_top)
  );

  always_ff @(posedge Clk) begin
    if (!Reset || bus.Start) begin
      err_q <= 1'b0;
    end else if (stk_fault) begin
      err_q <= 1'b1;
    end
  end

  assign bus.StackErr = Reset & err_q;
`else
  logic unused_pc;
  assign unused_pc    = ^bus.ProgCtr;
  assign bus.StackErr = 1'b0;
`endif

  // Table reads below see the pre-edge value, so a same-cycle write is not bypassed.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < 2**LUT_AW; i++) lut_q[i] <= '0;
    end else if (bus.LutWe) begin
      lut_q[bus.LutAddr] <= bus.LutData;
    end
  end

  // BEQ uses flag_q, never the CmpFlag being written this cycle.
  always_ff @(posedge Clk) begin
    if (!Reset || bus.Start) begin
      flag_q <= 1'b0;
    end else if (bus.FlagWr) begin
      flag_q <= bus.CmpFlag;
    end
  end

  always_comb begin
    br_en   = 1'b0;
    on_flag = 1'b0;
    tgt     = '0;
`ifdef BRANCH_RET_STACK_EN
    do_push   = 1'b0;
    do_pop    = 1'b0;
    stk_fault = 1'b0;
`endif
    case (bus.BrOp)
      BR_JMP: begin
        br_en = 1'b1;
        tgt   = lut_q[bus.BrIdx];
      end
      BR_BEQ: begin
        br_en   = 1'b1;
        on_flag = 1'b1;
        tgt     = lut_q[bus.BrIdx];
      end
      BR_CALL: begin
        // Branch is taken even when the push has to be dropped.
        br_en = 1'b1;
        tgt   = lut_q[bus.BrIdx];
`ifdef BRANCH_RET_STACK_EN
        do_push   = 1'b1;
        stk_fault = stk_full;
`endif
      end
      BR_RET: begin
`ifdef BRANCH_RET_STACK_EN
        if (!stk_empty) begin
          br_en  = 1'b1;
          tgt    = stk_top;
          do_pop = 1'b1;
        end else begin
          stk_fault = 1'b1;
        end
`endif
      end
      default: ;
    endcase
    if (!Reset || bus.Start) begin
      br_en   = 1'b0;
      on_flag = 1'b0;
      tgt     = '0;
`ifdef BRANCH_RET_STACK_EN
      do_push   = 1'b0;
      do_pop    = 1'b0;
      stk_fault = 1'b0;
`endif
    end
  end

  assign bus.BranchEn     = br_en;
  assign bus.BranchOnFlag = on_flag;
  assign bus.Target       = tgt;
  assign bus.branch_flag  = Reset & flag_q;

endmodule

// File: doc/branch_unit.md
# branch_unit

Branch-control block driving the branch side of the instruction fetch unit (`InstFetch`). It decodes the branch field of the current instruction and holds the ALU compare flag. It resolves jump targets through a loadable 16-entry target table and manages a small call/return stack. It then presents `BranchEn`, `BranchOnFlag`, `branch_flag` and `Target` to `InstFetch` for the same clock edge.

## Interface
Parameters:
- `PC_W`, 10: program counter / target width.
- `LUT_AW`, 4: target-table index width (16 entries).
- `STACK_DEPTH`, 4: return-stack entries.

Ports:
- `Clk`  in  1: single clock; all state updates on rising edge.
- `Reset`  in  1: synchronous, active-low reset (asserted when 0).
- `Start`  in  1: new-program strobe, same signal fed to `InstFetch`.
- `ProgCtr`  in  PC_W: current PC from `InstFetch`.
- `BrOp`  in  3: decoded branch op: NONE=0, JMP=1, BEQ=2, CALL=3, RET=4; codes 5–7 are treated as NONE.
- `BrIdx`  in  LUT_AW: target-table index from the instruction.
- `FlagWr`  in  1: latch `CmpFlag` this cycle.
- `CmpFlag`  in  1: ALU compare result.
- `LutWe`  in  1: target-table write enable.
- `LutAddr`  in  LUT_AW: target-table write index.
- `LutData`  in  PC_W: target-table write data.
- `BranchEn`  out  1: to `InstFetch`.
- `BranchOnFlag`  out  1: to `InstFetch`.
- `branch_flag`  out  1: to `InstFetch`, the registered compare flag.
- `Target`  out  PC_W: to `InstFetch`.
- `StackErr`  out  1: sticky overflow/underflow indicator.

## Operation
- Branch outputs are combinational from `BrOp`, `BrIdx`, table contents and stack top. Flag, table, stack and `StackErr` are registered.
- NONE: `BranchEn`=0, `BranchOnFlag`=0, `Target`=0.
- JMP: `BranchEn`=1, `BranchOnFlag`=0, `Target`=LUT[`BrIdx`].
- BEQ: `BranchEn`=1, `BranchOnFlag`=1, `Target`=LUT[`BrIdx`]. `InstFetch` branches only when `branch_flag`=1.
- CALL: behaves as JMP. On the edge it also pushes (`ProgCtr`+1) mod 2^PC_W.
- RET with stack non-empty: `BranchEn`=1, `BranchOnFlag`=0, `Target`=top of stack, popped on the edge.
- RET with stack empty: `BranchEn`=0, no pop, `StackErr` set.
- CALL with stack full: branch still taken, push dropped, stack unchanged, `StackErr` set.
- `FlagWr`=1 loads `CmpFlag` into the flag register. A BEQ in the same cycle uses the old flag; there is no bypass.
- `LutWe`=1 writes LUT[`LutAddr`]. A same-cycle read of that index returns the old value.
- `Start`=1 forces all branch outputs to 0 and suppresses push/pop. On that edge it clears the stack, the flag and `StackErr`. The table is preserved.

## Timing
- Reset (`Reset`=0 at an edge): flag=0, stack empty, `StackErr`=0, all table entries=0.
  - All outputs are 0 while `Reset`=0, regardless of `BrOp`.
  - Reset mid-program discards pending stack contents.
- Branch resolution has zero-cycle latency: outputs valid in the same cycle as `BrOp`, and `InstFetch` loads `Target` on that edge.
- Stack, flag and table updates are visible from the cycle after the edge.
- Precedence: `Reset` > `Start` > normal operation.

## Configuration
- `BRANCH_RET_STACK_EN` defined: CALL/RET behave as above, and the return stack and `StackErr` logic are present.
- `BRANCH_RET_STACK_EN` undefined: no stack is instantiated, CALL acts as JMP, RET acts as NONE, and `StackErr` is tied to 0.

## Structure
- `branch_pkg` holds the `BrOp` enum codes, `PC_W`/`LUT_AW` defaults and the op-width constant. Shared with the decoder.
- Sub-module `ret_stack`: parameterised LIFO with push/pop/full/empty/top outputs and synchronous active-low reset. It is instantiated only under `BRANCH_RET_STACK_EN`.

## Test plan
- Reset with `BrOp`=JMP held -> all outputs 0. After release, with LUT[3] written to 1000 and `BrOp`=JMP, `BrIdx`=3 -> `BranchEn`=1, `Target`=1000.
- `FlagWr`=1, `CmpFlag`=1 in the same cycle as BEQ -> `branch_flag` is 0 that cycle and 1 the next. BEQ with LUT[5]=300 -> `BranchOnFlag`=1, `Target`=300.
- CALL at `ProgCtr`=1023 -> stack top 0. Next-cycle RET -> `Target`=0 and stack empty.
- Five CALLs without RET (depth 4) -> fifth branches, `StackErr`=1. Four RETs return the first four pushed addresses in reverse order.
- RET on empty stack -> `BranchEn`=0, `StackErr`=1. `Start`=1 -> `StackErr` cleared, flag 0, table retained.
- Build without `BRANCH_RET_STACK_EN`: CALL with LUT[2]=77 -> `Target`=77. RET -> `BranchEn`=0, `StackErr` stays 0.
